// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one ce/we/addr/width/data/ready memory port among
// NUM_REQ clients; the grant is held until downstream ready or timeout.
module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_ce_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*4-1:0]      req_width_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [DATA_W-1:0]         req_data_o,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        req_err_o,
  output logic                      ds_ce_o,
  output logic                      ds_we_o,
  output logic [ADDR_W-1:0]         ds_addr_o,
  output logic [3:0]                ds_width_o,
  output logic [DATA_W-1:0]         ds_data_o,
  input  logic [DATA_W-1:0]         ds_data_i,
  input  logic                      ds_ready_i,
  output logic [NUM_REQ-1:0]        grant_o
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_gidx;
  logic [NUM_REQ-1:0] r_mask;
  logic [NUM_REQ-1:0] r_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_ready;
  logic [NUM_REQ-1:0] r_rerr;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_ds_ce;
  logic               r_ds_we;
  logic [ADDR_W-1:0]  r_ds_addr;
  logic [3:0]         r_ds_width;
  logic [DATA_W-1:0]  r_ds_data;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic [IDX_W-1:0]   w_next_ptr;
  int                 w_k;
  logic               w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [3:0]         w_width;
  logic [DATA_W-1:0]  w_data;

  assign w_elig     = req_ce_i & ~r_mask;
  assign w_pick_oh  = NUM_REQ'(1) << w_pick;
  assign w_next_ptr = (r_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gidx + IDX_W'(1);

  // Scan from the highest offset down so the closest index at/after rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_k     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_k = int'(r_rr_ptr) + i;
      if (w_k >= NUM_REQ) w_k = w_k - NUM_REQ;
      if (w_elig[w_k[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_k[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_width = '0;
    w_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == IDX_W'(i)) begin
        w_we    = req_we_i[i];
        w_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
        w_width = req_width_i[i*4 +: 4];
        w_data  = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_gidx     <= '0;
      r_mask     <= '0;
      r_grant    <= '0;
      r_cnt      <= '0;
      r_ready    <= '0;
      r_rerr     <= '0;
      r_rdata    <= '0;
      r_ds_ce    <= 1'b0;
      r_ds_we    <= 1'b0;
      r_ds_addr  <= '0;
      r_ds_width <= '0;
      r_ds_data  <= '0;
    end else begin
      r_ready <= '0;
      r_rerr  <= '0;
      case (r_state)
        S_IDLE: begin
          r_mask <= '0;
          if (w_found) begin
            r_ds_ce    <= 1'b1;
            r_ds_we    <= w_we;
            r_ds_addr  <= w_addr;
            r_ds_width <= w_width;
            r_ds_data  <= w_data;
            r_grant    <= w_pick_oh;
            r_gidx     <= w_pick;
            r_cnt      <= '0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (ds_ready_i) begin
            r_rdata <= ds_data_i;
            r_ds_ce <= 1'b0;
            r_ready <= r_grant;
            r_state <= S_RESP;
          end else if (TIMEOUT != 0 && r_cnt == CNT_LAST) begin
            r_rdata <= '0;
            r_ds_ce <= 1'b0;
            r_ready <= r_grant;
            r_rerr  <= r_grant;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          // Mask the served client for one IDLE cycle so a late-dropping ce cannot re-win.
          r_rr_ptr <= w_next_ptr;
          r_mask   <= r_grant;
          r_grant  <= '0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_data_o  = r_rdata;
  assign req_ready_o = r_ready;
  assign req_err_o   = r_rerr;
  assign ds_ce_o     = r_ds_ce;
  assign ds_we_o     = r_ds_we;
  assign ds_addr_o   = r_ds_addr;
  assign ds_width_o  = r_ds_width;
  assign ds_data_o   = r_ds_data;
  assign grant_o     = r_grant;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference of the round-robin/timeout rules.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req_ce = '0;
  logic [N-1:0]  req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*4-1:0]  req_width = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_rdata;
  logic [N-1:0]  req_ready, req_err, grant;
  logic          ds_ce, ds_we;
  logic [AW-1:0] ds_addr;
  logic [3:0]    ds_width;
  logic [DW-1:0] ds_wdata;
  logic [DW-1:0] ds_rdata = '0;
  logic          ds_ready = 1'b0;

  int n_tot = 0;
  int n_bad = 0;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_ce_i(req_ce), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_width_i(req_width), .req_data_i(req_wdata),
    .req_data_o(req_rdata), .req_ready_o(req_ready), .req_err_o(req_err),
    .ds_ce_o(ds_ce), .ds_we_o(ds_we), .ds_addr_o(ds_addr), .ds_width_o(ds_width),
    .ds_data_o(ds_wdata), .ds_data_i(ds_rdata), .ds_ready_i(ds_ready),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Reference: owner index (-1 none), busy-cycle count, response-cycle flag.
  int            m_owner = -1, m_busy = 0, m_rr = 0, m_mask = -1, m_pick, m_idx;
  bit            m_resp = 0, m_err = 0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [3:0]    m_width = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [N-1:0]  e_g;
  logic          pv_rst = 1'b0, pv_rdy = 1'b0;
  logic [N-1:0]  pv_ce = '0, pv_we = '0;
  logic [N*AW-1:0] pv_addr = '0;
  logic [N*4-1:0]  pv_width = '0;
  logic [N*DW-1:0] pv_wdata = '0;
  logic [DW-1:0] pv_rdata = '0;

  always @(negedge clk) begin
    if (!rst || !pv_rst) begin
      m_owner = -1; m_busy = 0; m_rr = 0; m_mask = -1; m_resp = 0; m_err = 0; m_rdata = '0;
      chk("rst_ctl", {ds_ce, ds_we, grant, req_ready, req_err, ds_width}, '0);
      chk("rst_data", {ds_addr, ds_wdata}, '0);
      chk("rst_rdata", req_rdata, '0);
    end else begin
      if (m_resp) begin
        m_rr = (m_owner + 1) % N; m_mask = m_owner; m_owner = -1; m_resp = 0;
      end else if (m_owner >= 0) begin
        if (pv_rdy) begin m_resp = 1; m_err = 0; m_rdata = pv_rdata; end
        else if (m_busy == TO) begin m_resp = 1; m_err = 1; m_rdata = '0; end
        else m_busy++;
      end else begin
        m_pick = -1;
        for (int k = 0; k < N; k++) begin
          m_idx = (m_rr + k) % N;
          if (m_pick < 0 && pv_ce[m_idx] && m_idx != m_mask) m_pick = m_idx;
        end
        m_mask = -1;
        if (m_pick >= 0) begin
          m_owner = m_pick; m_busy = 1;
          m_we    = pv_we[m_pick];
          m_addr  = pv_addr[m_pick*AW +: AW];
          m_width = pv_width[m_pick*4 +: 4];
          m_wdata = pv_wdata[m_pick*DW +: DW];
        end
      end
      e_g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      chk("ds_ce", ds_ce, (m_owner >= 0) && !m_resp);
      chk("grant", grant, e_g);
      chk("ready", req_ready, m_resp ? e_g : '0);
      chk("err", req_err, (m_resp && m_err) ? e_g : '0);
      chk("rdata", req_rdata, m_rdata);
      if (m_owner >= 0 && !m_resp) begin
        chk("ds_fields", {ds_we, ds_width, ds_addr}, {m_we, m_width, m_addr});
        chk("ds_wdata", ds_wdata, m_wdata);
      end
    end
    pv_rst = rst; pv_ce = req_ce; pv_we = req_we; pv_addr = req_addr;
    pv_width = req_width; pv_wdata = req_wdata; pv_rdy = ds_ready; pv_rdata = ds_rdata;
  end

  // Downstream responder and autonomous requesters, advanced once per cycle.
  int           ds_mode = -1;
  logic [DW-1:0] ds_fix = '0;
  bit           ds_act = 0;
  int           ds_left = 0;
  bit           auto_req = 0, cont = 0;
  logic [N-1:0] rdy_seen = '0;

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [3:0] w, input logic [DW-1:0] d);
    req_ce[i] = 1'b1; req_we[i] = we;
    req_addr[i*AW +: AW] = a; req_width[i*4 +: 4] = w; req_wdata[i*DW +: DW] = d;
  endtask

  task automatic new_req(input int i);
    set_req(i, 1'($urandom), $urandom, 4'($urandom), $urandom);
  endtask

  task automatic step();
    logic [N-1:0] rdy_prev;
    @(posedge clk); #1;
    rdy_prev = rdy_seen; rdy_seen = req_ready;
    ds_ready = 1'b0; ds_rdata = $urandom;
    if (!ds_ce) ds_act = 0;
    else if (!ds_act) begin
      ds_act = 1;
      if (ds_mode < 0) ds_left = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 8));
      else ds_left = ds_mode;
    end
    if (ds_act && ds_left > 0) begin
      ds_left--;
      if (ds_left == 0) begin ds_ready = 1'b1; if (ds_mode > 0) ds_rdata = ds_fix; end
    end else if (!ds_ce && ds_mode < 0 && $urandom_range(0, 7) == 0) ds_ready = 1'b1;
    if (auto_req)
      for (int i = 0; i < N; i++) begin
        if (rdy_prev[i]) begin
          if (cont || $urandom_range(0, 3) == 0) new_req(i); else req_ce[i] = 1'b0;
        end else if (!cont && !req_ce[i] && $urandom_range(0, 2) == 0) new_req(i);
      end
  endtask

  task automatic wait_ready(input int lim, output logic [N-1:0] r);
    r = '0;
    for (int c = 0; c < lim && r == '0; c++) begin step(); r = req_ready; end
    if (r == '0) chk("wait_ready_expired", 1, 0);
  endtask

  task automatic drain();
    auto_req = 0; cont = 0; req_ce = '0;
    repeat (30) step();
  endtask

  initial begin
    logic [N-1:0] r;
    int seq[$];
    int last_rdy_c, n_busy;
    bit prev_ce, done;

    repeat (3) step();
    chk("reset_grant", grant, '0);
    chk("reset_ready", req_ready, '0);
    rst = 1'b1;

    // All four requesting continuously from reset.
    step();
    for (int i = 0; i < N; i++) new_req(i);
    auto_req = 1; cont = 1; prev_ce = ds_ce; last_rdy_c = -1;
    for (int c = 0; c < 300 && seq.size() < 5; c++) begin
      step();
      if (ds_ce && !prev_ce) begin
        seq.push_back(oh2i(grant));
        if (last_rdy_c >= 0) chk("rr_gap", c - last_rdy_c, 2);
      end
      if (req_ready != '0) last_rdy_c = c;
      prev_ce = ds_ce;
    end
    chk("rr_count", seq.size(), 5);
    for (int k = 0; k < 5; k++) chk("rr_order", (k < seq.size()) ? seq[k] : -1, k % N);
    drain();

    // Single read from req1, response after 3 cycles.
    ds_mode = 3; ds_fix = 32'hDEADBEEF;
    step();
    chk("rd_ce_before", ds_ce, 0);
    set_req(1, 1'b0, 32'h100, 4'h4, '0);
    step();
    chk("rd_ce_latency", ds_ce, 1);
    chk("rd_addr", ds_addr, 32'h100);
    wait_ready(20, r);
    chk("rd_ready", r, 4'b0010);
    chk("rd_data", req_rdata, 32'hDEADBEEF);
    chk("rd_err", req_err, '0);
    step(); req_ce[1] = 1'b0;
    step();

    // rr_ptr is now 2: req2 before req0's write.
    ds_mode = 2; ds_fix = 32'h12345678;
    set_req(0, 1'b1, 32'h20, 4'hF, 32'h55);
    set_req(2, 1'b0, 32'h200, 4'h3, '0);
    wait_ready(20, r);
    chk("rr2_first", r, 4'b0100);
    chk("rr2_data", req_rdata, 32'h12345678);
    step(); req_ce[2] = 1'b0;
    step();
    chk("wr_grant", grant, 4'b0001);
    chk("wr_we", ds_we, 1);
    chk("wr_data", ds_wdata, 32'h55);
    chk("wr_addr", ds_addr, 32'h20);
    wait_ready(20, r);
    chk("wr_ready", r, 4'b0001);
    step(); req_ce[0] = 1'b0;
    step();

    // Stale ce from req3 for one cycle after ready is masked.
    ds_mode = 1;
    set_req(3, 1'b0, 32'h300, 4'h2, '0);
    wait_ready(20, r);
    chk("stale_ready", r, 4'b1000);
    step();
    step();
    chk("stale_masked", ds_ce, 0);
    req_ce[3] = 1'b0;
    step();
    chk("stale_no_regrant", ds_ce, 0);
    set_req(3, 1'b1, 32'h304, 4'h1, 32'hA5);
    wait_ready(20, r);
    step();
    step();
    chk("held_masked", ds_ce, 0);
    step();
    chk("held_regrant_ce", ds_ce, 1);
    chk("held_regrant", grant, 4'b1000);
    req_ce[3] = 1'b0;
    drain();

    // Timeout: no downstream ready at all.
    ds_mode = 0;
    set_req(1, 1'b0, 32'h400, 4'h4, '0);
    n_busy = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      if (ds_ce) n_busy++;
      else if (n_busy > 0) done = 1;
    end
    chk("to_busy_cycles", n_busy, TO);
    chk("to_ready", req_ready, 4'b0010);
    chk("to_err", req_err, 4'b0010);
    chk("to_rdata", req_rdata, '0);
    chk("to_ds_ce", ds_ce, 0);
    step(); req_ce[1] = 1'b0;
    drain();

    // Randomized traffic.
    ds_mode = -1; auto_req = 1; cont = 0;
    repeat (2500) step();
    drain();

    // Asynchronous reset while busy.
    ds_mode = 0;
    for (int i = 0; i < N; i++) new_req(i);
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin step(); done = ds_ce; end
    chk("busy_before_rst", ds_ce, 1);
    step();
    rst = 1'b0;
    #1;
    chk("arst_ctl", {ds_ce, ds_we, grant, req_ready, req_err, ds_width}, '0);
    chk("arst_data", {ds_addr, ds_wdata}, '0);
    chk("arst_rdata", req_rdata, '0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("post_rst_grant", grant, 4'b0001);
    ds_mode = -1;
    drain();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_tot, n_bad);
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory port (the ce/we/addr/width/data/ready interface consumed by mem_axi) among NUM_REQ processor memory clients.
- Sits between the proc instances and a single mem_axi, so several processors use one AXI master.
- Round-robin arbitration; the grant is held for the whole transaction until the downstream ready.
- Registered request path and per-transaction timeout with an error flag.

Parameters:
- NUM_REQ, 4, number of requesting processors (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 1024, max cycles waiting for ds_ready_i before abort; 0 disables

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_ce_i  in  NUM_REQ  per-requester request enable
- req_we_i  in  NUM_REQ  per-requester write enable
- req_addr_i  in  NUM_REQ x ADDR_W  per-requester address
- req_width_i  in  NUM_REQ x 4  per-requester access width
- req_data_i  in  NUM_REQ x DATA_W  per-requester write data
- req_data_o  out  DATA_W  read data, shared; valid only with req_ready_o bit
- req_ready_o  out  NUM_REQ  one-hot completion pulse
- req_err_o  out  NUM_REQ  one-hot timeout pulse, coincident with req_ready_o
- ds_ce_o  out  1  downstream request enable
- ds_we_o  out  1  downstream write enable
- ds_addr_o  out  ADDR_W  downstream address
- ds_width_o  out  4  downstream width
- ds_data_o  out  DATA_W  downstream write data
- ds_data_i  in  DATA_W  downstream read data
- ds_ready_i  in  1  downstream completion, 1-cycle pulse
- grant_o  out  NUM_REQ  current one-hot grant (debug)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk; reset port is rst (asserted when low).
- Reset state: all outputs 0, state IDLE, rr_ptr=0, timeout counter 0, mask 0. Reset mid-transaction abandons the transaction with no ready pulse; the downstream shares rst.
- Requester contract: hold ce and all fields stable until its ready bit pulses; the cycle after ready, either drop ce or present a new request.
- IDLE:
  - Eligible set = req_ce_i & ~mask.
  - Pick the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
  - If one is found: register its we/addr/width/data into ds_*, set ds_ce_o=1, set grant_o, clear the counter, go BUSY.
  - Downstream ce rises one cycle after request sampling (1-cycle arbitration latency).
  - mask is cleared at the end of every IDLE cycle.
- BUSY:
  - ds_* held constant; the counter increments each cycle.
  - On ds_ready_i: latch ds_data_i into req_data_o, ds_ce_o=0, go RESP.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: req_data_o=0, ds_ce_o=0, set the error flag, go RESP.
- RESP (exactly 1 cycle):
  - req_ready_o[g]=1; req_err_o[g]=error flag.
  - rr_ptr=(g+1) mod NUM_REQ; mask=one-hot(g); grant_o=0; go IDLE.
  - req_ready_o and req_err_o are 0 in all other cycles.
  - mask keeps a stale ce from the just-served requester from re-winning in the following IDLE cycle.
- Minimum transaction: request -> ds_ce_o 1 cycle later -> ready at the earliest the cycle after ds_ready_i. Back-to-back grants are separated by one IDLE cycle.
- Simultaneous requests are resolved purely by rr_ptr. Any request present continuously is served within NUM_REQ transactions (no starvation).
- ds_ready_i outside BUSY is ignored.
- A requester dropping ce while granted has no effect; the transaction completes.
- req_data_o holds its value between transactions; write transactions return ds_data_i as sampled.

Test Plan:
- Single read, req1 addr 0x100, downstream returns 0xDEADBEEF after 3 cycles: ds_ce_o rises 1 cycle after req, ds_addr_o=0x100, req_ready_o=4'b0010 pulse with req_data_o=0xDEADBEEF, req_err_o=0.
- All four request at once, continuously, from reset: grant order 0,1,2,3,0; each grant separated by exactly one IDLE cycle.
- Req0 write addr 0x20 data 0x55 and req2 read concurrently with rr_ptr=2: req2 served first; then ds_we_o=1, ds_data_o=0x55 for req0.
- Req3 keeps ce high 1 cycle after its ready with no other requester: the stale cycle is masked; a re-grant occurs only if ce is still high in the following IDLE cycle.
- TIMEOUT=8, ds_ready_i never asserted: exactly 8 BUSY cycles, then req_ready_o and req_err_o pulse for the grantee, req_data_o=0, ds_ce_o=0.
- rst driven low while BUSY: all outputs 0 asynchronously (before next clk edge); after release, first grant goes to req0.
